// File: rtl/cap_demux_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cap_demux_rx_pkg
// Brief    : Shared geometry and counter types for the capacitor MUX/DEMUX path.
// Revision : 1.0
// ============================================================================
package cap_demux_rx_pkg;
    localparam int C_WIDTH         = 8;
    localparam int C_CHANNEL_NUM   = 128;
    localparam int C_CAPACITOR_NUM = 70;
    localparam int C_ACT_CNT_W     = 8;
    localparam int C_IDLE_CNT_W    = 16;

    typedef logic [C_ACT_CNT_W-1:0]  act_cnt_t;
    typedef logic [C_IDLE_CNT_W-1:0] idle_cnt_t;
endpackage
`default_nettype wire

// File: rtl/cap_demux_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : cap_demux_rx_if
// Brief    : Frame/mask input bundle and reconstructed-channel output bundle.
// Revision : 1.0
// ============================================================================
interface cap_demux_rx_if #(
    parameter int WIDTH         = cap_demux_rx_pkg::C_WIDTH,
    parameter int CHANNEL_NUM   = cap_demux_rx_pkg::C_CHANNEL_NUM,
    parameter int CAPACITOR_NUM = cap_demux_rx_pkg::C_CAPACITOR_NUM
) ();
    logic                               in_valid;
    logic [WIDTH*CAPACITOR_NUM-1:0]     data_in;
    logic                               sw_load;
    logic [CAPACITOR_NUM-1:0]           sw;
    logic                               out_valid;
    logic [WIDTH*CHANNEL_NUM-1:0]       data_out;
    logic [CHANNEL_NUM-1:0]             chan_idle;
    cap_demux_rx_pkg::act_cnt_t         active_cnt;
    cap_demux_rx_pkg::idle_cnt_t        idle_frame_cnt;

    modport master (
        output in_valid, data_in, sw_load, sw,
        input  out_valid, data_out, chan_idle, active_cnt, idle_frame_cnt
    );

    modport slave (
        input  in_valid, data_in, sw_load, sw,
        output out_valid, data_out, chan_idle, active_cnt, idle_frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cap_demux_map.sv
`default_nettype none
// ============================================================================
// Module   : cap_demux_map
// Brief    : Combinational mask-to-channel mapper using a running prefix popcount.
// Revision : 1.0
// ============================================================================
module cap_demux_map #(
    parameter int WIDTH         = cap_demux_rx_pkg::C_WIDTH,
    parameter int CHANNEL_NUM   = cap_demux_rx_pkg::C_CHANNEL_NUM,
    parameter int CAPACITOR_NUM = cap_demux_rx_pkg::C_CAPACITOR_NUM
) (
    input  wire logic [CAPACITOR_NUM-1:0]       i_mask,
    input  wire logic [WIDTH*CAPACITOR_NUM-1:0] i_data,
    output logic      [WIDTH*CHANNEL_NUM-1:0]   o_data
);
    int w_prefix;

    // w_prefix is the count of enabled capacitors below k, i.e. k's destination channel.
    always_comb begin
        o_data   = '0;
        w_prefix = 0;
        for (int k = 0; k < CAPACITOR_NUM; k++) begin
            if (i_mask[k]) begin
                if (w_prefix < CHANNEL_NUM) begin
                    o_data[w_prefix*WIDTH +: WIDTH] = i_data[k*WIDTH +: WIDTH];
                end
                w_prefix = w_prefix + 1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/cap_demux_rx.sv
`default_nettype none
// ============================================================================
// Module   : cap_demux_rx
// Brief    : Two-stage capacitor-frame to channel-frame demultiplexer with idle stats.
// Revision : 1.0
// ============================================================================
module cap_demux_rx
    import cap_demux_rx_pkg::*;
#(
    parameter int WIDTH         = C_WIDTH,
    parameter int CHANNEL_NUM   = C_CHANNEL_NUM,
    parameter int CAPACITOR_NUM = C_CAPACITOR_NUM
) (
    input wire logic      clk,
    input wire logic      rst,
    cap_demux_rx_if.slave bus
);
    logic [CAPACITOR_NUM-1:0]       r_sw_shadow;
    logic [CAPACITOR_NUM-1:0]       r_s1_mask;
    logic [CAPACITOR_NUM-1:0]       w_eff_mask;
    logic [WIDTH*CAPACITOR_NUM-1:0] r_s1_data;
    logic                           r_s1_valid;
    logic                           r_out_valid;
    logic [WIDTH*CHANNEL_NUM-1:0]   w_map_data;
    logic [WIDTH*CHANNEL_NUM-1:0]   r_data_out;
    logic [CHANNEL_NUM-1:0]         w_idle;
    logic [CHANNEL_NUM-1:0]         r_chan_idle;
    act_cnt_t                       w_sw_pop;
    act_cnt_t                       r_active_cnt;
    idle_cnt_t                      r_idle_cnt;

    // A same-cycle load bypasses the shadow so the frame sees the new mask.
    assign w_eff_mask = bus.sw_load ? bus.sw : r_sw_shadow;

    always_comb begin
        w_sw_pop = '0;
        for (int k = 0; k < CAPACITOR_NUM; k++) begin
            w_sw_pop = w_sw_pop + act_cnt_t'(bus.sw[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_shadow  <= '1;
            r_active_cnt <= act_cnt_t'(CAPACITOR_NUM);
        end else if (bus.sw_load) begin
            r_sw_shadow  <= bus.sw;
            r_active_cnt <= w_sw_pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mask  <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_data <= bus.data_in;
                r_s1_mask <= w_eff_mask;
            end
        end
    end

    cap_demux_map #(
        .WIDTH         (WIDTH),
        .CHANNEL_NUM   (CHANNEL_NUM),
        .CAPACITOR_NUM (CAPACITOR_NUM)
    ) u_map (
        .i_mask (r_s1_mask),
        .i_data (r_s1_data),
        .o_data (w_map_data)
    );

    for (genvar j = 0; j < CHANNEL_NUM; j++) begin : g_idle
        assign w_idle[j] = (~|w_map_data[j*WIDTH +: WIDTH]) ^ (&w_map_data[j*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_chan_idle <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data_out  <= w_map_data;
                r_chan_idle <= w_idle;
                if ((&w_idle) && (r_idle_cnt != '1)) begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.data_out       = r_data_out;
    assign bus.chan_idle      = r_chan_idle;
    assign bus.active_cnt     = r_active_cnt;
    assign bus.idle_frame_cnt = r_idle_cnt;
endmodule
`default_nettype wire

// File: doc/cap_demux_rx.md
CAP_DEMUX_RX -- requirements
Module: cap_demux_rx

Interface
REQ-001 Parameter WIDTH, default 8: bits per channel word and per capacitor word; shared with the MUX path.
REQ-002 Parameter CHANNEL_NUM, default 128: number of reconstructed output channels.
REQ-003 Parameter CAPACITOR_NUM, default 70: number of capacitor words per input frame.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset; clears all state immediately on assertion.
REQ-006 in_valid  input  1  the frame on data_in is valid this cycle.
REQ-007 data_in  input  WIDTH*CAPACITOR_NUM  capacitor frame; word k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-008 sw_load  input  1  load sw into the enable shadow register this cycle.
REQ-009 sw  input  CAPACITOR_NUM  capacitor enable mask; bit k=1 means capacitor k carries channel data.
REQ-010 out_valid  output  1  data_out and chan_idle hold a valid reconstructed frame.
REQ-011 data_out  output  WIDTH*CHANNEL_NUM  channel frame; word j occupies bits [j*WIDTH+WIDTH-1 : j*WIDTH].
REQ-012 chan_idle  output  CHANNEL_NUM  bit j=1 when channel word j is all-0 or all-1.
REQ-013 active_cnt  output  8  popcount of the enable shadow register.
REQ-014 idle_frame_cnt  output  16  count of output frames in which every channel was idle.

Function
REQ-015 Enable shadow: sw_shadow SHALL load sw on any cycle with sw_load=1, independent of in_valid.
REQ-016 A frame accepted with sw_load=1 in the same cycle SHALL be mapped with the newly loaded sw value.
REQ-017 Stage 1: on in_valid=1, register data_in and the effective mask (sw if sw_load else sw_shadow); stage-1 valid follows in_valid.
REQ-018 Stage 2 mapping: channel j SHALL receive the capacitor word of the (j+1)-th set bit of the stage-1 mask, scanned from bit 0 upward.
REQ-019 Channels j >= popcount(mask) SHALL output all-zero words; disabled capacitor words SHALL be discarded.
REQ-020 If popcount(mask) > CHANNEL_NUM, capacitor words beyond the CHANNEL_NUM-th enabled one SHALL be discarded.
REQ-021 Latency: exactly 2 cycles from in_valid sampled high to out_valid high with the corresponding frame; no backpressure, one frame per cycle sustained.
REQ-022 out_valid SHALL deassert 2 cycles after in_valid deasserts; data_out and chan_idle SHALL hold their last values while out_valid=0.
REQ-023 chan_idle[j] SHALL be computed from the stage-2 word j (all-0 XOR all-1) and registered together with data_out.
REQ-024 idle_frame_cnt SHALL increment by 1 for each out_valid frame with chan_idle all ones, saturating at 16'hFFFF.
REQ-025 active_cnt SHALL reflect sw_shadow one cycle after it loads; the count is an unsigned 8-bit popcount.

Reset
REQ-026 On rst: out_valid=0, data_out=0, chan_idle=0, idle_frame_cnt=0, stage-1 valid=0.
REQ-027 On rst: sw_shadow = all ones, active_cnt = CAPACITOR_NUM.
REQ-028 Reset asserted mid-stream SHALL drop all in-flight frames; the first frame after release appears 2 cycles after its in_valid.

Structure
REQ-029 WIDTH, CHANNEL_NUM and CAPACITOR_NUM SHALL come from the shared parameter include also used by the MUX path; no local redefinition.
REQ-030 Mapping SHALL use a prefix-popcount over the mask to give each capacitor its destination channel index.
REQ-031 One sub-module, cap_demux_map (combinational mask-to-channel mapper), SHALL be instantiated; the pipeline registers and counters stay in cap_demux_rx.

Verification
REQ-032 Reset release, sw untouched; frame with word k = k (k=0..69) -> after 2 cycles channels 0..69 = 0..69, channels 70..127 = 0, active_cnt=70.
REQ-033 sw_load with mask = only bits 3,10,69 set, same-cycle frame words 3=8'hA5, 10=8'h5A, 69=8'h3C -> channel0=A5, channel1=5A, channel2=3C, others 0, active_cnt=3.
REQ-034 Mask all zero, any frame -> data_out all zero, chan_idle all ones, idle_frame_cnt increments by 1 per valid frame.
REQ-035 Back-to-back 10 frames then in_valid low -> 10 consecutive out_valid cycles starting at cycle 2, out_valid low 2 cycles after last input, data_out held.
REQ-036 Assert rst for 1 cycle while 2 frames are in flight -> out_valid stays 0, no stale frame emitted, counters cleared, sw_shadow all ones.
